// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO feeding the UART transmit engine through a load/txrdy handshake.
// Firmware bursts bytes in at full clock rate; the FSM releases one per completed engine cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          txrdy,
  output logic          load,
  output logic [7:0]    tx_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovf,
  input  logic          clr_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_LO,
    WAIT_HI
  } state_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic [7:0]    tx_data_q;
  logic          pop;
  logic          push;
  logic          drop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign ovf     = ovf_q;
  assign tx_data = tx_data_q;

  // A write into a full FIFO still lands if a byte leaves on the same edge.
  assign push = wr_en & (~full | pop);
  assign drop = wr_en & full & ~pop;

  // NOTE: every output of this block is given a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && txrdy) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_d = WAIT_LO;
      end
      // The engine may keep txrdy high for a few cycles after load; wait for it to actually go busy.
      WAIT_LO: if (!txrdy) state_d = WAIT_HI;
      WAIT_HI: if (txrdy)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wp_q      <= '0;
      rp_q      <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q <= state_d;
      if (push) wp_q <= wp_q + AW'(1);
      if (pop) begin
        rp_q      <= rp_q + AW'(1);
        tx_data_q <= mem_q[rp_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; count and pointers already mark its contents invalid, and a resettable array would cost a flop per bit.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based model of the buffer and the load/txrdy handshake,
// compared against the DUT every cycle, plus hand-computed expectations per scenario.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          txrdy;
  logic          load;
  logic [7:0]    tx_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          ovf;
  logic          clr_ovf;

  int n_err = 0;
  int n_chk = 0;

  // Model: byte queue, handshake progress flags, latched output byte, sticky overflow.
  byte unsigned m_q[$];
  bit           m_busy     = 1'b0;
  bit           m_seen_low = 1'b0;
  bit           m_load     = 1'b0;
  bit           m_ovf      = 1'b0;
  logic [7:0]   m_tx       = 8'h00;

  logic [7:0]   got[$];

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .txrdy   (txrdy),
    .load    (load),
    .tx_data (tx_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .ovf     (ovf),
    .clr_ovf (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs that were stable before it.
  task automatic model_step();
    bit full_pre;
    bit pop;
    if (reset !== 1'b1) begin
      m_q.delete();
      m_busy = 0; m_seen_low = 0; m_load = 0; m_ovf = 0; m_tx = 8'h00;
      return;
    end
    full_pre = (m_q.size() == DEPTH);
    pop      = !m_busy && (m_q.size() != 0) && (txrdy === 1'b1);
    // A transfer is complete once txrdy has been seen low after the load cycle and then high again.
    if (m_load)                 m_load = 0;
    else if (m_busy) begin
      if (!m_seen_low) begin
        if (txrdy === 1'b0) m_seen_low = 1;
      end else if (txrdy === 1'b1) m_busy = 0;
    end
    if (pop) begin
      m_tx       = m_q.pop_front();
      m_busy     = 1;
      m_seen_low = 0;
      m_load     = 1;
    end
    if (wr_en === 1'b1 && (!full_pre || pop)) m_q.push_back(wr_data);
    if (wr_en === 1'b1 && full_pre && !pop)   m_ovf = 1;
    else if (clr_ovf === 1'b1)                m_ovf = 0;
  endtask

  task automatic compare_all();
    check("cyc_load",    32'(load),    32'(m_load));
    check("cyc_tx_data", 32'(tx_data), 32'(m_tx));
    check("cyc_count",   32'(count),   32'(m_q.size()));
    check("cyc_empty",   32'(empty),   32'(m_q.size() == 0));
    check("cyc_full",    32'(full),    32'(m_q.size() == DEPTH));
    check("cyc_ovf",     32'(ovf),     32'(m_ovf));
  endtask

  // One clock: model on the rising edge, compare on the falling edge; inputs change only after this returns.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (load === 1'b1) got.push_back(tx_data);
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    cycle();
    wr_en   = 1'b0;
  endtask

  // Transmit engine: drops txrdy the cycle load is seen and stays busy for busy_len cycles.
  task automatic run_engine(input int ncyc, input int busy_len);
    int b = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (load === 1'b1) b = busy_len;
      txrdy = (b == 0);
      if (b > 0) b--;
      cycle();
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 8'hxx;
  endfunction

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; txrdy = 1'b0; clr_ovf = 1'b0;
    cycle();
    cycle();
    check("rst_count",   32'(count),   32'd0);
    check("rst_empty",   32'(empty),   32'd1);
    check("rst_full",    32'(full),    32'd0);
    check("rst_load",    32'(load),    32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_ovf",     32'(ovf),     32'd0);
    reset = 1'b1;
    cycle();

    // Single byte: load arrives two edges after the write and lasts one cycle.
    txrdy = 1'b1;
    got.delete();
    write_byte(8'hA5);
    check("single_e0_load",  32'(load),  32'd0);
    check("single_e0_count", 32'(count), 32'd1);
    cycle();
    check("single_e1_load",  32'(load),    32'd1);
    check("single_e1_data",  32'(tx_data), 32'hA5);
    check("single_e1_count", 32'(count),   32'd0);
    write_byte(8'h5A);
    check("single_load_1cyc", 32'(load), 32'd0);
    txrdy = 1'b0;
    repeat (3) cycle();
    check("single_no_2nd_load", 32'(got.size()), 32'd1);
    txrdy = 1'b1;
    repeat (4) cycle();
    check("single_2nd_loads", 32'(got.size()), 32'd2);
    check("single_2nd_data",  32'(got_at(1)),  32'h5A);
    txrdy = 1'b0;
    cycle();
    txrdy = 1'b1;
    repeat (3) cycle();

    // Ordering, wrap and drop on a full FIFO.
    txrdy = 1'b0;
    got.delete();
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    check("fill_full",  32'(full),  32'd1);
    check("fill_count", 32'(count), 32'd16);
    write_byte(8'h10);
    check("drop_ovf",   32'(ovf),   32'd1);
    check("drop_count", 32'(count), 32'd16);
    run_engine(300, 10);
    check("order_nloads", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16; i++) check("order_byte", 32'(got_at(i)), 32'(i));
    check("order_empty", 32'(empty), 32'd1);

    // Overflow flag: set beats clear in the same cycle.
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);
    txrdy = 1'b0;
    for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i));
    write_byte(8'hEE);
    check("ovf_set", 32'(ovf), 32'd1);
    clr_ovf = 1'b1;
    write_byte(8'hEF);
    check("ovf_set_wins", 32'(ovf),   32'd1);
    check("ovf_drop_cnt", 32'(count), 32'd16);
    cycle();
    clr_ovf = 1'b0;
    check("ovf_clr_alone", 32'(ovf), 32'd0);

    // Push and pop together at full: 0x30 is accepted and follows 0x21..0x2F.
    got.delete();
    txrdy = 1'b1;
    write_byte(8'h30);
    check("pp_count", 32'(count), 32'd16);
    check("pp_ovf",   32'(ovf),   32'd0);
    check("pp_load",  32'(load),  32'd1);
    run_engine(300, 10);
    check("pp_nloads", 32'(got.size()), 32'd17);
    for (int i = 0; i < 17; i++) check("pp_byte", 32'(got_at(i)), 32'h20 + 32'(i));
    check("pp_empty", 32'(empty), 32'd1);

    // Engine that never drops ready: FSM parks after the first load.
    txrdy = 1'b1;
    got.delete();
    write_byte(8'h61);
    write_byte(8'h62);
    repeat (20) cycle();
    check("stuck_nloads", 32'(got.size()), 32'd1);
    check("stuck_data",   32'(got_at(0)),  32'h61);
    check("stuck_count",  32'(count),      32'd1);
    txrdy = 1'b0;
    cycle();
    txrdy = 1'b1;
    repeat (4) cycle();
    check("stuck_release_nloads", 32'(got.size()), 32'd2);
    check("stuck_release_data",   32'(got_at(1)),  32'h62);
    txrdy = 1'b0;
    cycle();
    txrdy = 1'b1;
    repeat (3) cycle();

    // Reset while waiting for the engine to finish: queued bytes vanish.
    got.delete();
    write_byte(8'h71);
    write_byte(8'h72);
    write_byte(8'h73);
    txrdy = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
    txrdy = 1'b1;
    repeat (2) cycle();
    check("mrst_count",   32'(count),   32'd0);
    check("mrst_empty",   32'(empty),   32'd1);
    check("mrst_load",    32'(load),    32'd0);
    check("mrst_tx_data", 32'(tx_data), 32'h00);
    reset = 1'b1;
    got.delete();
    repeat (20) cycle();
    check("mrst_no_loads", 32'(got.size()), 32'd0);
    check("mrst_count_after", 32'(count),   32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer between the TramelBlaze output port and the UART transmit engine. Accepts bytes written by the processor at full clock rate, stores up to DEPTH of them, and hands them one at a time to the transmit engine using its `load`/`txrdy` handshake. Firmware can burst a message and take one interrupt on drain instead of one per byte.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..256.
- AW, 4: pointer width; must equal log2(DEPTH).

- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- wr_en  in  1  write request (port-decoded write strobe); one byte per cycle.
- wr_data  in  8  byte to enqueue (out_port[7:0]).
- txrdy  in  1  transmit engine idle/ready.
- load  out  1  one-cycle pulse to the transmit engine; tx_data valid during it.
- tx_data  out  8  byte presented to the transmit engine; held until next load.
- empty  out  1  FIFO holds no bytes.
- full  out  1  FIFO holds DEPTH bytes.
- count  out  AW+1  bytes currently stored, 0..DEPTH.
- ovf  out  1  sticky: a write was dropped.
- clr_ovf  in  1  clears ovf.

## Operation
- Storage: DEPTH x 8 array; write pointer `wp` and read pointer `rp`, AW bits each, wrap from DEPTH-1 to 0; `count` is a separate AW+1-bit register. empty = (count==0), full = (count==DEPTH), both combinational from count.
- Push: wr_en & (~full | pop) writes wr_data at wp, increments wp.
- Drop: wr_en & full & ~pop drops the byte; ovf <= 1. Array, wp, and count are unchanged.
- Pop: occurs on the edge where the FSM leaves IDLE for LOAD. tx_data <= mem[rp], rp increments.
- Count: +1 on push only, -1 on pop only, unchanged on push and pop together.
- ovf: set wins over clr_ovf in the same cycle.
- FSM, states IDLE, LOAD, WAIT_LO, WAIT_HI:
  - IDLE: if ~empty & txrdy, pop and go to LOAD; otherwise stay.
  - LOAD: load = 1 for exactly this cycle; go to WAIT_LO unconditionally.
  - WAIT_LO: stay while txrdy = 1; on txrdy = 0 go to WAIT_HI. This guards against the engine's ready flag lagging load by one or more cycles.
  - WAIT_HI: stay while txrdy = 0; on txrdy = 1 go to IDLE.
- load is decoded from state == LOAD only. No other state asserts it.
- Reset (reset = 0, any time): state IDLE, load 0, tx_data 8'h00, wp = rp = 0, count 0, empty 1, full 0, ovf 0.
  - Stored bytes are discarded and array contents are don't-care.
  - A character already in the transmit engine is not affected.

## Timing
- Write at edge E0 into an empty FIFO with txrdy = 1:
  - count = 1 and empty = 0 after E0.
  - At E1: pop and enter LOAD, so load is high in the cycle after E1 with tx_data = the byte. count returns to 0 at E1.
  - First-byte latency: 2 edges from write to load.
- Back-to-back loads are separated by at least 3 cycles (LOAD, WAIT_LO, WAIT_HI, IDLE), plus the engine's busy time.
- wr_en is sampled every cycle. The push path never stalls; the only loss case is the drop condition.
- Push and pop on the same edge: the written byte is never the one popped unless count was 0. Pop is inhibited at count = 0, so a simultaneous write into an empty FIFO is popped one edge later.
- txrdy is assumed synchronous to clk and is not resynchronized.
- Pointer wrap: after DEPTH pushes, wp returns to 0. Ordering is preserved across the wrap.

## Test plan
- Reset mid-stream: load 3 bytes, assert reset = 0 while in WAIT_HI -> after release: count = 0, empty = 1, load = 0, tx_data = 8'h00, state IDLE; no further loads occur.
- Single byte, txrdy tied 1 then dropped 1 cycle after load: write 8'hA5 -> load pulses exactly one cycle, 2 edges after the write, with tx_data = 8'hA5; no second load until txrdy falls and rises again.
- Ordering and wrap, DEPTH = 16: with txrdy = 0, write 8'h00..8'h0F -> full = 1, count = 16. Then write 8'h10 -> dropped, ovf = 1. Release txrdy with an engine model (busy 10 cycles per byte) -> exactly 16 loads, in order 8'h00..8'h0F; empty = 1 at end.
- Simultaneous push/pop at full: with full = 1, write in the same cycle the FSM pops -> byte accepted, count stays 16, ovf stays 0, byte emitted 16th in sequence.
- ovf priority: ovf = 1, then assert clr_ovf in the same cycle as a dropped write -> ovf remains 1. Next cycle clr_ovf alone -> ovf = 0.
- Stuck txrdy = 1 engine that never drops ready: write 2 bytes -> first load issues, FSM holds in WAIT_LO, no second load while txrdy stays 1.
